// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmitter state encoding, keyboard command bytes
// and the frame parity helper.
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        REQ,
        SHIFT,
        ACK,
        WAIT_IDLE
    } ps2_tx_state_e;

    localparam logic [7:0] CMD_SET_LED = 8'hED;
    localparam logic [7:0] CMD_RESET   = 8'hFF;
    localparam logic [7:0] CMD_ENABLE  = 8'hF4;
    localparam logic [7:0] CMD_RESEND  = 8'hFE;

    // Parity bit that makes the nine transmitted bits contain an odd number of ones.
    function automatic logic odd_parity(input logic [7:0] data);
        return ~^data;
    endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// Byte-level request/status bundle between a command source (master) and the
// PS/2 host transmitter (slave).
interface ps2_host_tx_if;

    logic       tx_valid_i;
    logic [7:0] tx_data_i;
    logic       tx_ready_o;
    logic       tx_done_o;
    logic       tx_err_o;
    logic       busy_o;

    modport master (
        output tx_valid_i,
        output tx_data_i,
        input  tx_ready_o,
        input  tx_done_o,
        input  tx_err_o,
        input  busy_o
    );

    modport slave (
        input  tx_valid_i,
        input  tx_data_i,
        output tx_ready_o,
        output tx_done_o,
        output tx_err_o,
        output busy_o
    );

endinterface

// File: rtl/ps2_line_sync.sv
// Conditions one raw PS/2 line: 2-flop synchronizer, optional stability filter
// (PS2_TX_FILTER_EN) and falling-edge detect. Shareable with the receiver.
module ps2_line_sync #(
    parameter int FILT_LEN = 8
) (
    input  logic clk_i,
    input  logic res_n_i,
    input  logic line_i,
    output logic line_o,
    output logic fall_o
);

    logic sync_p0;
    logic sync_p1;
    logic line_q;
    logic prev_q;

    // Idle level of an open-drain line is high, so reset to 1 to avoid a false fall.
    always_ff @(posedge clk_i or negedge res_n_i) begin
        if (!res_n_i) begin
            sync_p0 <= 1'b1;
            sync_p1 <= 1'b1;
        end else begin
            sync_p0 <= line_i;
            sync_p1 <= sync_p0;
        end
    end

`ifdef PS2_TX_FILTER_EN
    localparam int FILT_W = $clog2(FILT_LEN) + 1;

    logic [FILT_W-1:0] filt_cnt_q;
    logic              filt_q;

    always_ff @(posedge clk_i or negedge res_n_i) begin
        if (!res_n_i) begin
            filt_q     <= 1'b1;
            filt_cnt_q <= '0;
        end else if (sync_p1 == filt_q) begin
            filt_cnt_q <= '0;
        end else if (filt_cnt_q == FILT_W'(FILT_LEN - 1)) begin
            filt_q     <= sync_p1;
            filt_cnt_q <= '0;
        end else begin
            filt_cnt_q <= filt_cnt_q + 1'b1;
        end
    end

    assign line_q = filt_q;
`else
    localparam int FILT_LEN_UNUSED = FILT_LEN;

    assign line_q = sync_p1;
`endif

    always_ff @(posedge clk_i or negedge res_n_i) begin
        if (!res_n_i) begin
            prev_q <= 1'b1;
        end else begin
            prev_q <= line_q;
        end
    end

    assign line_o = line_q;
    assign fall_o = prev_q & ~line_q;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device byte transmitter driving open-drain clock/data low-enables.
// Define PS2_TX_FILTER_EN to add the FILT_LEN-sample glitch filter on both lines.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYC = 2400,
    parameter int TIMEOUT_CYC = 360000,
    parameter int FILT_LEN    = 8
) (
    input  logic         clk_i,
    input  logic         res_n_i,
    ps2_host_tx_if.slave tx_if,
    input  logic         ps2_clk_i,
    input  logic         ps2_dat_i,
    output logic         ps2_clk_oe_o,
    output logic         ps2_dat_oe_o
);

    localparam int CNT_MAX = (TIMEOUT_CYC > INHIBIT_CYC) ? TIMEOUT_CYC : INHIBIT_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYC - 1);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYC - 1);

    ps2_tx_state_e    state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [3:0]       bitcnt_q;
    logic [8:0]       shift_q;
    logic             clk_oe_q;
    logic             dat_oe_q;
    logic             ready_q;
    logic             done_q;
    logic             err_q;
    logic             busy_q;

    logic clk_s;
    logic clk_fall;
    logic dat_s;
    logic dat_fall_unused;
    logic accept;
    logic shift_en;

    ps2_line_sync #(.FILT_LEN(FILT_LEN)) u_clk_sync (
        .clk_i   (clk_i),
        .res_n_i (res_n_i),
        .line_i  (ps2_clk_i),
        .line_o  (clk_s),
        .fall_o  (clk_fall)
    );

    ps2_line_sync #(.FILT_LEN(FILT_LEN)) u_dat_sync (
        .clk_i   (clk_i),
        .res_n_i (res_n_i),
        .line_i  (ps2_dat_i),
        .line_o  (dat_s),
        .fall_o  (dat_fall_unused)
    );

    assign accept   = (state_q == IDLE) && tx_if.tx_valid_i && ready_q;
    assign shift_en = clk_fall && ((state_q == REQ) || ((state_q == SHIFT) && (bitcnt_q < 4'd8)));

    // Frame data needs no reset: it is always loaded on acceptance before use.
    always_ff @(posedge clk_i) begin
        if (accept) begin
            shift_q <= {odd_parity(tx_if.tx_data_i), tx_if.tx_data_i};
        end else if (shift_en) begin
            shift_q <= {1'b1, shift_q[8:1]};
        end
    end

    always_ff @(posedge clk_i or negedge res_n_i) begin
        if (!res_n_i) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            bitcnt_q <= '0;
            clk_oe_q <= 1'b0;
            dat_oe_q <= 1'b0;
            ready_q  <= 1'b1;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    clk_oe_q <= 1'b0;
                    dat_oe_q <= 1'b0;
                    if (accept) begin
                        state_q  <= INHIBIT;
                        cnt_q    <= '0;
                        clk_oe_q <= 1'b1;
                        ready_q  <= 1'b0;
                        busy_q   <= 1'b1;
                    end
                end
                // Clock is held low here, so line edges are our own and ignored.
                INHIBIT: begin
                    if (cnt_q == INH_LAST) begin
                        state_q  <= REQ;
                        cnt_q    <= '0;
                        clk_oe_q <= 1'b0;
                        dat_oe_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                REQ, SHIFT, ACK, WAIT_IDLE: begin
                    if ((state_q == WAIT_IDLE) && clk_s && dat_s) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                    end else if (clk_fall) begin
                        // A device edge always beats a coincident timeout.
                        cnt_q <= '0;
                        case (state_q)
                            REQ: begin
                                dat_oe_q <= ~shift_q[0];
                                bitcnt_q <= '0;
                                state_q  <= SHIFT;
                            end
                            SHIFT: begin
                                if (bitcnt_q == 4'd8) begin
                                    dat_oe_q <= 1'b0;
                                    bitcnt_q <= 4'd9;
                                    state_q  <= ACK;
                                end else begin
                                    dat_oe_q <= ~shift_q[0];
                                    bitcnt_q <= bitcnt_q + 1'b1;
                                end
                            end
                            ACK: begin
                                done_q  <= ~dat_s;
                                err_q   <= dat_s;
                                state_q <= WAIT_IDLE;
                            end
                            default: ;
                        endcase
                    end else if (cnt_q == TO_LAST) begin
                        clk_oe_q <= 1'b0;
                        dat_oe_q <= 1'b0;
                        err_q    <= (state_q != WAIT_IDLE);
                        state_q  <= IDLE;
                        cnt_q    <= '0;
                        ready_q  <= 1'b1;
                        busy_q   <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ps2_clk_oe_o     = clk_oe_q;
    assign ps2_dat_oe_o     = dat_oe_q;
    assign tx_if.tx_ready_o = ready_q;
    assign tx_if.tx_done_o  = done_q;
    assign tx_if.tx_err_o   = err_q;
    assign tx_if.busy_o     = busy_q;

endmodule
